xy_dac_arbiter: RTL and testbench
=================================

Name: xy_dac_arbiter

Overview:
- Shares the single X/Y DAC pair of the vector display between two point-stream requesters, e.g. the triangle-wave image generator and a vector/glyph point source.
- Round-robin arbitration between the two requesters.
- Each accepted point is held on the DACs for a settle window with the beam blanked, then for a programmable dwell window with the beam unblanked.
- Sits between the point sources and the DAC pins/blank output.

Parameters:
- SETTLE_CYCLES, default 4: blanked cycles after each DAC update. 0 means no settle window.
- DWELL_W, default 8: width of dwell_cycles and of the dwell counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a point
- req0_x  in  8  requester 0 X coordinate
- req0_y  in  8  requester 0 Y coordinate
- req0_ready  out  1  requester 0 point accepted this cycle
- req1_valid  in  1  requester 1 has a point
- req1_x  in  8  requester 1 X coordinate
- req1_y  in  8  requester 1 Y coordinate
- req1_ready  out  1  requester 1 point accepted this cycle
- dwell_cycles  in  DWELL_W  unblanked hold time per point, sampled at accept
- xdac  out  8  X DAC code (registered)
- ydac  out  8  Y DAC code (registered)
- blank  out  1  1 = beam off (registered)
- grant_id  out  1  source of the point currently on the DACs (registered)
- busy  out  1  1 when state != IDLE

Behaviour:
- Reset: all outputs and state are updated on the clk edge while reset=1.
  - State=IDLE, xdac=0, ydac=0, blank=1, grant_id=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Counters cleared.
  - Reset mid-SETTLE or mid-DWELL aborts the point immediately; nothing is replayed.
- FSM states: IDLE, SETTLE, DWELL.
- Arbitration (combinational, only in IDLE):
  - g0 = req0_valid & (~req1_valid | last_grant==1)
  - g1 = req1_valid & (~req0_valid | last_grant==0)
  - reqN_ready = (state==IDLE) & gN.
  - Both ready outputs are 0 outside IDLE and during reset.
  - Never both 1 in the same cycle.
- Accept: handshake when reqN_valid & reqN_ready in cycle T. At the T+1 edge:
  - xdac/ydac <= reqN_x/reqN_y
  - grant_id <= N, last_grant <= N
  - dwell_latched <= max(dwell_cycles, 1); a value of 0 is treated as 1
  - blank <= 1
  - state <= SETTLE, or DWELL directly if SETTLE_CYCLES=0.
- SETTLE:
  - blank=1 for exactly SETTLE_CYCLES cycles (T+1..T+S).
  - Then state <= DWELL.
- DWELL:
  - blank=0 for exactly dwell_latched cycles (T+S+1..T+S+D).
  - Then state <= IDLE with blank=1 at T+S+D+1.
- Throughput and point hold:
  - Earliest next accept is cycle T+S+D+1, so the period per point is S+D+1 cycles.
  - xdac/ydac/grant_id hold their last value until the next accept, including while in IDLE.
- Input stability: changes to req*_x/y or dwell_cycles after accept have no effect on the current point.
- Single-requester streaming: if only one requester is valid, it is granted every IDLE cycle, since round-robin only applies under contention.
- Starvation bound: under continuous contention, grants strictly alternate 0,1,0,1…
- Withdrawn requests: deasserting valid in a non-IDLE cycle is legal; the requester is simply not granted.
- Counters:
  - Settle counter width is ceil(log2(SETTLE_CYCLES+1)).
  - Dwell counter is DWELL_W bits, counting down from dwell_latched to 1.
  - No wrap-around is possible.

Test Plan:
1. Reset, then req0_valid=1, x=0x12, y=0x34, dwell=3, S=4, req1 idle.
   - Expected: req0_ready=1 at T.
   - xdac=0x12, ydac=0x34, blank=1 for T+1..T+4.
   - blank=0 for T+5..T+7.
   - blank=1 and req0_ready=1 again at T+8.
2. Both requesters valid continuously, req0 (0x10,0x10), req1 (0x20,0x20), dwell=2.
   - Expected grant sequence 0,1,0,1, each accept 7 cycles apart.
   - grant_id and xdac track the sequence.
3. dwell_cycles=0 at accept.
   - Expected: exactly 1 unblanked cycle.
   - Changing dwell_cycles to 9 during SETTLE does not alter that point.
4. Assert reset during DWELL of a point at (0xAA,0x55).
   - Expected next cycle: xdac=0, ydac=0, blank=1, busy=0.
   - After reset release with both requesters valid, requester 0 is granted first.
5. Instance with SETTLE_CYCLES=0, dwell=1, req1 streaming alone.
   - Expected: accept every 2 cycles.
   - blank pattern 1,0,1,0…; req0_ready stays 0.
6. Both ready outputs checked every cycle.
   - Expected: never simultaneously 1, and never 1 while busy=1.

Source files
------------

// File: rtl/xy_dac_arbiter.sv
// xy_dac_arbiter
// Shares one X/Y DAC pair between two point-stream requesters.
// Requesters are served round-robin. Each accepted point goes through two
// windows on the DACs:
//   1. A settle window of SETTLE_CYCLES cycles with the beam blanked.
//   2. A dwell window of max(dwell_cycles, 1) cycles with the beam unblanked.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req0_valid/x/y    requester 0 point and valid
//   req0_ready        requester 0 point accepted this cycle
//   req1_valid/x/y    requester 1 point and valid
//   req1_ready        requester 1 point accepted this cycle
//   dwell_cycles      unblanked hold time, sampled when a point is accepted
//   xdac, ydac        registered DAC codes
//   blank             registered beam blank (1 = beam off)
//   grant_id          registered source of the point on the DACs
//   busy              1 while a point is being settled or dwelled
module xy_dac_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DWELL_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [7:0]         req0_x,
  input  logic [7:0]         req0_y,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [7:0]         req1_x,
  input  logic [7:0]         req1_y,
  output logic               req1_ready,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [7:0]         xdac,
  output logic [7:0]         ydac,
  output logic               blank,
  output logic               grant_id,
  output logic               busy
);

  // A zero-cycle settle window still needs a 1-bit counter to stay legal.
  localparam int unsigned SCW = (SETTLE_CYCLES > 32'd0) ? $clog2(SETTLE_CYCLES + 32'd1) : 32'd1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [7:0]         xdac_q, xdac_d;
  logic [7:0]         ydac_q, ydac_d;
  logic               blank_q, blank_d;
  logic               grant_q, grant_d;
  logic               g0_s, g1_s, idle_s;
  logic [DWELL_W-1:0] dwell_load_s;

  // Round-robin arbitration: under contention the requester that did not win
  // last time gets the grant.
  always_comb begin
    g0_s       = req0_valid & (~req1_valid | last_grant_q);
    g1_s       = req1_valid & (~req0_valid | ~last_grant_q);
    idle_s     = (state_q == ST_IDLE) & ~reset;
    req0_ready = idle_s & g0_s;
    req1_ready = idle_s & g1_s;
  end

  // A dwell request of zero still shows the point for one cycle.
  always_comb begin
    if (dwell_cycles == '0) begin
      dwell_load_s = DWELL_W'(1);
    end else begin
      dwell_load_s = dwell_cycles;
    end
  end

  // Next-state logic for the point sequencer and its registered outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    settle_cnt_d = settle_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    xdac_d       = xdac_q;
    ydac_d       = ydac_q;
    blank_d      = blank_q;
    grant_d      = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready | req1_ready) begin
          xdac_d       = req1_ready ? req1_x : req0_x;
          ydac_d       = req1_ready ? req1_y : req0_y;
          grant_d      = req1_ready;
          last_grant_d = req1_ready;
          dwell_cnt_d  = dwell_load_s;
          settle_cnt_d = SETTLE_LOAD;
          if (SETTLE_CYCLES == 32'd0) begin
            state_d = ST_DWELL;
            blank_d = 1'b0;
          end else begin
            state_d = ST_SETTLE;
            blank_d = 1'b1;
          end
        end else begin
          blank_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q <= SCW'(1)) begin
          state_d = ST_DWELL;
          blank_d = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q - SCW'(1);
        end
      end
      ST_DWELL: begin
        if (dwell_cnt_q <= DWELL_W'(1)) begin
          state_d = ST_IDLE;
          blank_d = 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        blank_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any point in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      settle_cnt_q <= '0;
      dwell_cnt_q  <= '0;
      xdac_q       <= 8'd0;
      ydac_q       <= 8'd0;
      blank_q      <= 1'b1;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      settle_cnt_q <= settle_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      xdac_q       <= xdac_d;
      ydac_q       <= ydac_d;
      blank_q      <= blank_d;
      grant_q      <= grant_d;
    end
  end

  assign xdac     = xdac_q;
  assign ydac     = ydac_q;
  assign blank    = blank_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xy_dac_arbiter.sv
// Directed bench for xy_dac_arbiter. It uses two instances:
//   dut_a  default settle window (4 cycles)
//   dut_b  no settle window
// Accepted points are pushed to a scoreboard and compared against the DAC
// registers one cycle later.
module tb_xy_dac_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_v0, a_v1, a_r0, a_r1, a_blank, a_gid, a_busy;
  logic [7:0] a_x0, a_y0, a_x1, a_y1, a_dw, a_xdac, a_ydac;
  logic       b_v0, b_v1, b_r0, b_r1, b_blank, b_gid, b_busy;
  logic [7:0] b_x0, b_y0, b_x1, b_y1, b_dw, b_xdac, b_ydac;

  xy_dac_arbiter #(.SETTLE_CYCLES(4), .DWELL_W(8)) dut_a (
    .clk(clk), .reset(rst),
    .req0_valid(a_v0), .req0_x(a_x0), .req0_y(a_y0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_x(a_x1), .req1_y(a_y1), .req1_ready(a_r1),
    .dwell_cycles(a_dw), .xdac(a_xdac), .ydac(a_ydac), .blank(a_blank),
    .grant_id(a_gid), .busy(a_busy)
  );

  xy_dac_arbiter #(.SETTLE_CYCLES(0), .DWELL_W(8)) dut_b (
    .clk(clk), .reset(rst),
    .req0_valid(b_v0), .req0_x(b_x0), .req0_y(b_y0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_x(b_x1), .req1_y(b_y1), .req1_ready(b_r1),
    .dwell_cycles(b_dw), .xdac(b_xdac), .ydac(b_ydac), .blank(b_blank),
    .grant_id(b_gid), .busy(b_busy)
  );

  typedef struct packed {
    logic       g;
    logic [7:0] x;
    logic [7:0] y;
  } pt_t;

  pt_t  sb_a[$];
  pt_t  sb_b[$];
  int   acc_cyc_a[$];
  logic acc_g_a[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t0;
  int   ones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle. Inputs must already be set when this is called.
  // Mid-cycle: check the ready invariants and record any handshake.
  // After the edge: compare the DAC registers against the scoreboard.
  task automatic step();
    pt_t  e;
    logic pa;
    logic pb;
    pa = 1'b0;
    pb = 1'b0;
    #1;
    chk("a_ready_both",  {31'd0, a_r0 & a_r1}, 32'd0);
    chk("a_ready_busy",  {31'd0, a_busy & (a_r0 | a_r1)}, 32'd0);
    chk("b_ready_both",  {31'd0, b_r0 & b_r1}, 32'd0);
    chk("b_ready_busy",  {31'd0, b_busy & (b_r0 | b_r1)}, 32'd0);
    if (a_v0 && a_r0) begin
      sb_a.push_back({1'b0, a_x0, a_y0});
      acc_cyc_a.push_back(cyc);
      acc_g_a.push_back(1'b0);
      pa = 1'b1;
    end else if (a_v1 && a_r1) begin
      sb_a.push_back({1'b1, a_x1, a_y1});
      acc_cyc_a.push_back(cyc);
      acc_g_a.push_back(1'b1);
      pa = 1'b1;
    end
    if (b_v0 && b_r0) begin
      sb_b.push_back({1'b0, b_x0, b_y0});
      pb = 1'b1;
    end else if (b_v1 && b_r1) begin
      sb_b.push_back({1'b1, b_x1, b_y1});
      pb = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pa) begin
      e = sb_a.pop_front();
      chk("a_point", {15'd0, a_gid, a_xdac, a_ydac}, {15'd0, e});
      chk("a_blank_at_accept", {31'd0, a_blank}, 32'd1);
    end
    if (pb) begin
      e = sb_b.pop_front();
      chk("b_point", {15'd0, b_gid, b_xdac, b_ydac}, {15'd0, e});
      chk("b_blank_at_accept", {31'd0, b_blank}, 32'd0);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    a_v0 = 1'b0;
    a_v1 = 1'b0;
    b_v0 = 1'b0;
    b_v1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    acc_cyc_a.delete();
    acc_g_a.delete();
  endtask

  initial begin
    rst  = 1'b1;
    a_v0 = 1'b0; a_v1 = 1'b0; a_x0 = 8'd0; a_y0 = 8'd0; a_x1 = 8'd0; a_y1 = 8'd0; a_dw = 8'd0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_x0 = 8'd0; b_y0 = 8'd0; b_x1 = 8'd0; b_y1 = 8'd0; b_dw = 8'd0;
    @(negedge clk);
    step();
    step();

    // Reset state, and ready held low while reset is asserted.
    chk("rst_xdac",  {24'd0, a_xdac}, 32'd0);
    chk("rst_ydac",  {24'd0, a_ydac}, 32'd0);
    chk("rst_blank", {31'd0, a_blank}, 32'd1);
    chk("rst_gid",   {31'd0, a_gid}, 32'd0);
    chk("rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("rst_b_blank", {31'd0, b_blank}, 32'd1);
    a_v0 = 1'b1;
    #1;
    chk("rst_ready0", {31'd0, a_r0}, 32'd0);
    step();
    rst = 1'b0;
    acc_cyc_a.delete();
    acc_g_a.delete();

    // Single point: 4 blanked settle cycles, 3 unblanked dwell cycles.
    a_x0 = 8'h12; a_y0 = 8'h34; a_dw = 8'd3;
    t0 = cyc;
    step();
    chk("t1_accepts", 32'(acc_cyc_a.size()), 32'd1);
    chk("t1_accept_cyc", 32'(acc_cyc_a[0]), 32'(t0));
    a_x0 = 8'h77;
    for (int k = 1; k <= 7; k++) begin
      chk("t1_blank", {31'd0, a_blank}, (k <= 4) ? 32'd1 : 32'd0);
      chk("t1_busy",  {31'd0, a_busy}, 32'd1);
      chk("t1_xdac_hold", {24'd0, a_xdac}, 32'h12);
      step();
    end
    chk("t1_end_blank", {31'd0, a_blank}, 32'd1);
    chk("t1_end_busy",  {31'd0, a_busy}, 32'd0);
    chk("t1_idle_xdac", {24'd0, a_xdac}, 32'h12);
    #1;
    chk("t1_ready_again", {31'd0, a_r0}, 32'd1);
    a_v0 = 1'b0;
    step();

    // Continuous contention: grants alternate 0,1,0,1, one every 7 cycles.
    do_reset();
    a_x0 = 8'h10; a_y0 = 8'h10; a_x1 = 8'h20; a_y1 = 8'h20; a_dw = 8'd2;
    a_v0 = 1'b1; a_v1 = 1'b1;
    for (int i = 0; i < 40 && acc_cyc_a.size() < 4; i++) begin
      step();
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
    chk("t2_accepts", 32'(acc_cyc_a.size()), 32'd4);
    for (int i = 0; i < acc_cyc_a.size(); i++) begin
      chk("t2_grant", {31'd0, acc_g_a[i]}, 32'(i % 2));
      if (i > 0) begin
        chk("t2_spacing", 32'(acc_cyc_a[i] - acc_cyc_a[i-1]), 32'd7);
      end
    end
    for (int i = 0; i < 8; i++) step();

    // Zero dwell gives one unblanked cycle; a later dwell change is ignored.
    do_reset();
    a_x0 = 8'h3C; a_y0 = 8'hC3; a_dw = 8'd0; a_v0 = 1'b1;
    step();
    a_v0 = 1'b0;
    a_dw = 8'd9;
    ones = 0;
    for (int k = 1; k <= 15; k++) begin
      if (a_blank === 1'b0) ones++;
      step();
    end
    chk("t3_accepts", 32'(acc_cyc_a.size()), 32'd1);
    chk("t3_unblanked", 32'(ones), 32'd1);

    // Reset during dwell aborts the point; requester 0 wins afterwards.
    do_reset();
    a_x0 = 8'hAA; a_y0 = 8'h55; a_dw = 8'd5; a_v0 = 1'b1;
    step();
    a_v0 = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t4_in_dwell_blank", {31'd0, a_blank}, 32'd0);
    chk("t4_in_dwell_busy",  {31'd0, a_busy}, 32'd1);
    chk("t4_in_dwell_xdac",  {24'd0, a_xdac}, 32'hAA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_xdac",  {24'd0, a_xdac}, 32'd0);
    chk("t4_ydac",  {24'd0, a_ydac}, 32'd0);
    chk("t4_blank", {31'd0, a_blank}, 32'd1);
    chk("t4_busy",  {31'd0, a_busy}, 32'd0);
    acc_cyc_a.delete();
    acc_g_a.delete();
    a_x0 = 8'h01; a_y0 = 8'h02; a_x1 = 8'h03; a_y1 = 8'h04; a_dw = 8'd1;
    a_v0 = 1'b1; a_v1 = 1'b1;
    step();
    a_v0 = 1'b0; a_v1 = 1'b0;
    chk("t4_accepts", 32'(acc_cyc_a.size()), 32'd1);
    chk("t4_first_gid", {31'd0, a_gid}, 32'd0);
    for (int i = 0; i < 8; i++) step();

    // No settle window, dwell 1, requester 1 alone: accept every 2 cycles.
    do_reset();
    b_v1 = 1'b1; b_y1 = 8'hA5; b_dw = 8'd1;
    for (int k = 0; k < 8; k++) begin
      b_x1 = 8'(k + 8'h50);
      chk("t5_blank", {31'd0, b_blank}, (k % 2 == 0) ? 32'd1 : 32'd0);
      #1;
      chk("t5_ready1", {31'd0, b_r1}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t5_ready0", {31'd0, b_r0}, 32'd0);
      step();
    end
    b_v1 = 1'b0;
    step();

    chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
    chk("sb_b_empty", 32'(sb_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
